psum_requant: RTL
=================

PSUM_REQUANT -- requirements
Module: psum_requant

Interface
REQ-001 Parameter ACC_LEN, default 9, SHALL set the number of PE partial sums accumulated per output pixel (legal range 1..1024).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 psum_valid  input  1  upstream PE opsum beat valid.
REQ-005 psum_ready  output  1  block accepts a psum beat this cycle.
REQ-006 psum  input  32  signed partial sum from PE.
REQ-007 scale  input  16  unsigned requant multiplier.
REQ-008 shift  input  5  requant right-shift amount, 0..31.
REQ-009 relu_en  input  1  clamp output floor to zero-point 128.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 out_data  output  8  unsigned activation, zero-point 128, the ifmap format the PE consumes.

Function
REQ-013 A psum beat SHALL transfer only when psum_valid and psum_ready are both 1 in the same cycle.
REQ-014 FSM states SHALL be IDLE, ACCUM, MULT, OUT; IDLE SHALL be the only reset state.
REQ-015 IDLE/ACCUM: psum_ready=1; each beat adds psum into a 32-bit signed accumulator with two's-complement wrap; the first beat of a group loads the accumulator instead of adding.
REQ-016 A beat counter SHALL count 0..ACC_LEN-1; IDLE->ACCUM on the first beat; the beat at count ACC_LEN-1 SHALL move to MULT and clear the counter (ACC_LEN=1: IDLE->MULT directly).
REQ-017 scale, shift, relu_en SHALL be captured on the first beat of a group and held until the group's output handshakes; mid-group changes are ignored.
REQ-018 MULT (exactly one cycle): p = acc * scale as 48-bit signed; if shift>0, r = (p + 2^(shift-1)) >>> shift, else r = p; then MULT->OUT.
REQ-019 y = r + 128; out_data = clamp(y, lo, 255), where lo = 128 if relu_en else 0; comparisons on full width, no intermediate truncation.
REQ-020 Latency: last beat accepted at cycle t -> out_valid=1 at cycle t+2.
REQ-021 OUT: out_valid=1, psum_ready=0; out_data SHALL be held stable until out_valid&&out_ready, then OUT->IDLE in the next cycle.
REQ-022 psum_ready SHALL be 0 in MULT and OUT; no beat is lost or double-counted under upstream stalls (psum_valid gaps).

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, counter 0, accumulator 0, captured config 0, out_valid 0, out_data 0, psum_ready 0; psum_ready SHALL be 1 from the first clock edge after rst deasserts.
REQ-024 Reset mid-group or in OUT SHALL discard the partial group; no out_valid pulse results from it.

Structure
REQ-025 Zero-point 128, uint8 clamp bounds, and the FSM state enum SHALL live in the shared accelerator package used with PE.
REQ-026 The requant datapath (multiply, round-shift, zero-point add, clamp) SHALL be a sub-module named requant_core, purely combinational and registered by psum_requant.

Verification
REQ-027 ACC_LEN=4, psum 10,20,30,40, scale=1, shift=0, relu_en=0 -> out_data=228, out_valid 2 cycles after the 4th beat.
REQ-028 ACC_LEN=1, psum=3, scale=1, shift=1 -> 130; psum=-3, same config -> 127 (round-half-up check).
REQ-029 ACC_LEN=1, psum=-300, scale=1, shift=0 -> 0; psum=-5 with relu_en=1 -> 128; psum=1000 -> 255.
REQ-030 ACC_LEN=4, out_ready held 0 for 5 cycles in OUT -> out_data stable, psum_ready=0 throughout, single transfer when out_ready=1.
REQ-031 ACC_LEN=4, rst asserted after 2 beats, then 4 beats of 1 with scale=1, shift=0 -> out_data=132 only; no earlier out_valid.
REQ-032 ACC_LEN=2, psum_valid toggling every other cycle, scale changed between beats -> result uses the scale captured on beat 1.

Source files
------------

// File: rtl/psum_requant_pkg.sv
// Shared accelerator package: activation zero-point, uint8 bounds,
// requant FSM states and the captured per-group config bundle.
package psum_requant_pkg;

  localparam int ZP     = 128;
  localparam int U8_MIN = 0;
  localparam int U8_MAX = 255;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    MULT,
    OUT
  } state_t;

  typedef struct packed {
    logic [15:0] scale;
    logic [4:0]  shift;
    logic        relu_en;
  } cfg_t;

endpackage

// File: rtl/requant_core.sv
// Combinational requant: multiply, round-half-up shift,
// zero-point add and uint8 clamp (optionally floored at zero-point).
module requant_core
  import psum_requant_pkg::*;
(
  input  logic signed [31:0] acc,
  input  cfg_t               cfg,
  output logic        [7:0]  q
);

  // 50 bits keeps product plus rounding term free of overflow
  logic signed [49:0] p;
  logic signed [49:0] rnd;
  logic signed [49:0] r;
  logic signed [49:0] y;
  logic signed [49:0] lo;

  always_comb begin
    p   = 50'(acc) * $signed({34'd0, cfg.scale});
    rnd = '0;
    if (cfg.shift != 5'd0)
      rnd = 50'sd1 <<< (cfg.shift - 5'd1);
    r   = (p + rnd) >>> cfg.shift;
    y   = r + 50'(ZP);
    lo  = cfg.relu_en ? 50'(ZP) : 50'(U8_MIN);
    if (y > 50'(U8_MAX))
      q = 8'(U8_MAX);
    else if (y < lo)
      q = lo[7:0];
    else
      q = y[7:0];
  end

endmodule

// File: rtl/psum_requant.sv
// Accumulates ACC_LEN PE partial sums per pixel, then requantises
// the total to a zero-point-128 uint8 activation.
module psum_requant
  import psum_requant_pkg::*;
#(
  parameter int ACC_LEN = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psum_valid,
  output logic        psum_ready,
  input  logic [31:0] psum,
  input  logic [15:0] scale,
  input  logic [4:0]  shift,
  input  logic        relu_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data
);

  localparam int CW = $clog2(ACC_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);

  state_t             state;
  state_t             nxt;
  logic [CW-1:0]      cnt;
  logic signed [31:0] acc;
  cfg_t               cfg;
  logic               run;
  logic               beat;
  logic               last;
  logic [7:0]         q;

  // run holds ready low until the first edge after reset
  assign psum_ready = run && (state == IDLE || state == ACCUM);
  assign beat       = psum_valid && psum_ready;
  assign last       = (cnt == LAST);
  assign out_valid  = (state == OUT);

  requant_core u_core (
    .acc (acc),
    .cfg (cfg),
    .q   (q)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (beat) nxt = last ? MULT : ACCUM;
      ACCUM: if (beat && last) nxt = MULT;
      MULT:  nxt = OUT;
      OUT:   if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      run      <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      cfg      <= '0;
      out_data <= '0;
    end else begin
      state <= nxt;
      run   <= 1'b1;
      if (beat) begin
        cnt <= last ? '0 : cnt + CW'(1);
        if (state == IDLE) begin
          acc <= $signed(psum);
          cfg <= '{scale: scale, shift: shift, relu_en: relu_en};
        end else begin
          acc <= acc + $signed(psum);
        end
      end
      if (state == MULT)
        out_data <= q;
    end
  end

endmodule
